dual_port_ram_arbiter: RTL and testbench
========================================

Name: dual_port_ram_arbiter

Overview:
- Sits between two client masters and the 4-entry x 4-bit dual_port_ram, with both RAM ports clocked from the single clk.
- Maps client 0 to RAM port A and client 1 to RAM port B.
- Detects same-address hazards and serializes them with round-robin priority.
- Returns read data with a 1-cycle rvalid strobe per client and keeps a saturating conflict counter for debug.

Parameters:
- DW, 4, data width (matches dina/dinb).
- AW, 2, address width (matches address_a/address_b).
- CW, 8, conflict counter width.

Ports:
- clk  in  1  single clock; drives both RAM ports (clka/clkb tied to clk at top level).
- rst_n  in  1  asynchronous, active-low reset.
- c0_req  in  1  client 0 access request; held with its fields stable until c0_gnt.
- c0_we  in  1  client 0 write (1) / read (0).
- c0_addr  in  AW  client 0 address.
- c0_wdata  in  DW  client 0 write data.
- c0_gnt  out  1  client 0 access issued this cycle.
- c0_rvalid  out  1  client 0 read data valid.
- c0_rdata  out  DW  client 0 read data.
- c1_req, c1_we, c1_addr, c1_wdata, c1_gnt, c1_rvalid, c1_rdata: same as client 0, for client 1.
- ram_ena  out  1  to RAM ena.
- ram_wra  out  1  to RAM wra.
- ram_addr_a  out  AW  to RAM address_a.
- ram_dina  out  DW  to RAM dina.
- ram_douta  in  DW  from RAM douta; registered, 1-cycle read latency.
- ram_enb, ram_wrb, ram_addr_b, ram_dinb, ram_doutb: same as port A, for RAM port B.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, named clk and rst_n.
  - While rst_n=0: pri=0, conflict_cnt=0, c0_rvalid=c1_rvalid=0, c0_rdata=c1_rdata=0.
  - While rst_n=0, combinational outputs are forced to 0: c0_gnt, c1_gnt, ram_ena, ram_enb, ram_wra, ram_wrb. ram_addr_*/ram_din* are don't-care.
- Conflict definition: conflict = c0_req & c1_req & (c0_addr==c1_addr) & (c0_we|c1_we).
  - Read-read to the same address is not a conflict; both are granted.
- Grant logic (combinational from req and the registered pri):
  - No conflict: cN_gnt = cN_req.
  - Conflict: winner = pri (0 = client 0, 1 = client 1). Only the winner is granted; the loser's gnt=0 and it must hold its request.
- RAM drive, port A (port B identical for client 1):
  - ram_ena = c0_gnt; ram_wra = c0_gnt & c0_we; ram_addr_a = c0_addr; ram_dina = c0_wdata.
  - When c0_gnt=0: ram_ena=0 and ram_wra=0.
- Priority register: on a conflict cycle, pri <= ~winner at the next clk edge (loser wins the next conflict). Unchanged on non-conflict cycles.
  - Guarantee: a held loser is granted on the very next cycle.
- Read return: at clk edge, cN_rvalid <= cN_gnt & ~cN_we.
  - When rvalid=1, cN_rdata = the matching ram_dout (registered copy taken the cycle after the grant).
  - rdata holds its last value when rvalid=0.
  - Read latency: gnt at cycle T, rvalid/rdata at cycle T+1.
  - Back-to-back reads give continuous rvalid.
- Write completion: writes complete at the grant edge; no response strobe.
- Conflict counter: conflict_cnt increments by 1 per conflict cycle and saturates at 2^CW-1 (no wrap).
  - Internal register only; no port. Verification observes it hierarchically.
- Non-conflicting simultaneous write plus read to different addresses: both granted the same cycle.
- Ordering: a read granted in the cycle after a conflicting write to the same address returns the new data.
- Reset mid-operation: an outstanding rvalid is dropped; pri returns to 0.
- Undefined: any change of cN_addr/cN_we/cN_wdata while cN_req=1 and cN_gnt=0.

Test Plan:
1. Reset then idle: rst_n=0 with both req=1 -> all gnt=0, ram_ena=ram_enb=0, rvalid=0. Release -> grants appear the same cycle.
2. Parallel writes: c0 writes addr0=4'h5, c1 writes addr1=4'hA, both gnt=1 in one cycle. Then c0 reads addr1 and c1 reads addr0 -> next cycle c0_rvalid=1 with c0_rdata=4'hA, c1_rvalid=1 with c1_rdata=4'h5.
3. Write-write conflict at addr2 (c0 wdata=4'h3, c1 wdata=4'hC), pri=0 -> cycle T: c0_gnt=1, c1_gnt=0. Cycle T+1: c1_gnt=1. Read addr2 afterwards -> 4'hC; conflict_cnt=1; pri=1.
4. Read-write conflict at addr3 (mem=4'h7), c0 reads, c1 writes 4'h9, pri=1 -> write granted first. c0 read granted the next cycle and returns 4'h9 one cycle later; pri=0 after the first cycle.
5. Read-read same address addr0 -> both gnt=1 the same cycle; both rdata equal; conflict_cnt unchanged.
6. 300 consecutive conflict cycles -> grants alternate every cycle and conflict_cnt saturates at 255. Assert rst_n=0 asynchronously mid-read -> rvalid falls immediately and conflict_cnt=0.

Source files
------------

// File: rtl/dual_port_ram_arbiter.sv
// Two-client arbiter in front of a 4x4 dual-port RAM: client 0 drives port A, client 1 drives port B.
// Same-address hazards involving a write are serialized with a round-robin priority bit.
module dual_port_ram_arbiter #(
   parameter int DW = 4,
   parameter int AW = 2,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          c0_req,
   input  logic          c0_we,
   input  logic [AW-1:0] c0_addr,
   input  logic [DW-1:0] c0_wdata,
   output logic          c0_gnt,
   output logic          c0_rvalid,
   output logic [DW-1:0] c0_rdata,
   input  logic          c1_req,
   input  logic          c1_we,
   input  logic [AW-1:0] c1_addr,
   input  logic [DW-1:0] c1_wdata,
   output logic          c1_gnt,
   output logic          c1_rvalid,
   output logic [DW-1:0] c1_rdata,
   output logic          ram_ena,
   output logic          ram_wra,
   output logic [AW-1:0] ram_addr_a,
   output logic [DW-1:0] ram_dina,
   input  logic [DW-1:0] ram_douta,
   output logic          ram_enb,
   output logic          ram_wrb,
   output logic [AW-1:0] ram_addr_b,
   output logic [DW-1:0] ram_dinb,
   input  logic [DW-1:0] ram_doutb
);

   logic          conflict;
   logic          pri;
   logic [CW-1:0] conflict_cnt;
   logic [DW-1:0] c0_rdata_q;
   logic [DW-1:0] c1_rdata_q;

   // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
   always_comb begin
      conflict   = c0_req & c1_req & (c0_addr == c1_addr) & (c0_we | c1_we);
      c0_gnt     = rst_n & c0_req & ~(conflict & pri);
      c1_gnt     = rst_n & c1_req & ~(conflict & ~pri);
      ram_ena    = c0_gnt;
      ram_wra    = c0_gnt & c0_we;
      ram_addr_a = c0_addr;
      ram_dina   = c0_wdata;
      ram_enb    = c1_gnt;
      ram_wrb    = c1_gnt & c1_we;
      ram_addr_b = c1_addr;
      ram_dinb   = c1_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pri          <= 1'b0;
         conflict_cnt <= '0;
         c0_rvalid    <= 1'b0;
         c1_rvalid    <= 1'b0;
         c0_rdata_q   <= '0;
         c1_rdata_q   <= '0;
      end else begin
         if (conflict) begin
            pri <= ~pri;
            if (conflict_cnt != {CW{1'b1}}) begin
               conflict_cnt <= conflict_cnt + 1'b1;
            end
         end
         c0_rvalid <= c0_gnt & ~c0_we;
         c1_rvalid <= c1_gnt & ~c1_we;
         if (c0_rvalid) begin
            c0_rdata_q <= ram_douta;
         end
         if (c1_rvalid) begin
            c1_rdata_q <= ram_doutb;
         end
      end
   end

   // Live RAM output during the valid cycle, then the captured copy is held.
   assign c0_rdata = c0_rvalid ? ram_douta : c0_rdata_q;
   assign c1_rdata = c1_rvalid ? ram_doutb : c1_rdata_q;

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Randomized and directed bench for dual_port_ram_arbiter with a behavioural RAM,
// a reference model predicting grants, and a scoreboard for read returns.
module tb_dual_port_ram_arbiter;

   typedef struct {
      logic [3:0] data;
      int         due;
   } rd_exp_t;

   logic       clk;
   logic       rst_n;
   logic       c0_req, c0_we, c1_req, c1_we;
   logic [1:0] c0_addr, c1_addr;
   logic [3:0] c0_wdata, c1_wdata;
   logic       c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
   logic [3:0] c0_rdata, c1_rdata;
   logic       ram_ena, ram_wra, ram_enb, ram_wrb;
   logic [1:0] ram_addr_a, ram_addr_b;
   logic [3:0] ram_dina, ram_dinb, ram_douta, ram_doutb;
   logic [3:0] ram_mem [4] = '{default: 4'h0};

   int         checks = 0;
   int         errors = 0;
   int         cycle = 0;
   logic [3:0] m_mem [4];
   logic       m_pri;
   int         m_cnt;
   logic       mg0, mg1;
   logic [3:0] last0, last1;
   rd_exp_t    q0[$];
   rd_exp_t    q1[$];
   rd_exp_t    e0, e1;

   dual_port_ram_arbiter #(.DW(4), .AW(2), .CW(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
      .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
      .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
      .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
      .ram_ena(ram_ena), .ram_wra(ram_wra), .ram_addr_a(ram_addr_a),
      .ram_dina(ram_dina), .ram_douta(ram_douta),
      .ram_enb(ram_enb), .ram_wrb(ram_wrb), .ram_addr_b(ram_addr_b),
      .ram_dinb(ram_dinb), .ram_doutb(ram_doutb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle++;

   // Behavioural dual-port RAM with registered outputs.
   always @(posedge clk) begin
      if (ram_ena) begin
         if (ram_wra) ram_mem[ram_addr_a] <= ram_dina;
         ram_douta <= ram_wra ? ram_dina : ram_mem[ram_addr_a];
      end
      if (ram_enb) begin
         if (ram_wrb) ram_mem[ram_addr_b] <= ram_dinb;
         ram_doutb <= ram_wrb ? ram_dinb : ram_mem[ram_addr_b];
      end
   end

   task automatic checkVal(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Predict this cycle's grants from the arbitration rules, compare, then advance the model.
   task automatic checkOutput();
      logic conf;
      rd_exp_t e;
      conf = c0_req && c1_req && (c0_addr == c1_addr) && (c0_we || c1_we);
      mg0  = c0_req && !(conf && m_pri);
      mg1  = c1_req && !(conf && !m_pri);
      checkVal("c0_gnt", c0_gnt, mg0);
      checkVal("c1_gnt", c1_gnt, mg1);
      checkVal("ram_wra", ram_wra, mg0 && c0_we);
      checkVal("ram_wrb", ram_wrb, mg1 && c1_we);
      checkVal("pri", dut.pri, m_pri);
      checkVal("conflict_cnt", dut.conflict_cnt, m_cnt);
      if (mg0) begin
         checkVal("ram_addr_a", ram_addr_a, c0_addr);
         if (c0_we) checkVal("ram_dina", ram_dina, c0_wdata);
      end
      if (mg1) begin
         checkVal("ram_addr_b", ram_addr_b, c1_addr);
         if (c1_we) checkVal("ram_dinb", ram_dinb, c1_wdata);
      end
      if (mg0 && !c0_we) begin
         e.data = m_mem[c0_addr];
         e.due  = cycle + 1;
         q0.push_back(e);
      end
      if (mg1 && !c1_we) begin
         e.data = m_mem[c1_addr];
         e.due  = cycle + 1;
         q1.push_back(e);
      end
      if (mg0 && c0_we) m_mem[c0_addr] = c0_wdata;
      if (mg1 && c1_we) m_mem[c1_addr] = c1_wdata;
      if (conf) begin
         m_pri = !m_pri;
         if (m_cnt < 255) m_cnt++;
      end
   endtask

   task automatic applyStimulus(input logic r0, input logic w0, input logic [1:0] a0,
                                input logic [3:0] d0, input logic r1, input logic w1,
                                input logic [1:0] a1, input logic [3:0] d1);
      @(posedge clk);
      #1;
      c0_req = r0; c0_we = w0; c0_addr = a0; c0_wdata = d0;
      c1_req = r1; c1_we = w1; c1_addr = a1; c1_wdata = d1;
      @(negedge clk);
      checkOutput();
   endtask

   task automatic resetModel();
      m_pri = 1'b0;
      m_cnt = 0;
      last0 = 4'h0;
      last1 = 4'h0;
      q0.delete();
      q1.delete();
   endtask

   // Scoreboard monitor: pops an expectation whenever a client presents rvalid.
   always @(negedge clk) begin
      if (rst_n) begin
         if (c0_rvalid) begin
            checks++;
            if (q0.size() == 0) begin
               errors++;
               $display("[TB] FAIL c0_rvalid_extra: got rvalid=1, expected 0 (cycle %0d)", cycle);
            end else begin
               e0 = q0.pop_front();
               if (c0_rdata !== e0.data || e0.due != cycle) begin
                  errors++;
                  $display("[TB] FAIL c0_rdata: got %h at cycle %0d, expected %h at cycle %0d",
                           c0_rdata, cycle, e0.data, e0.due);
               end
               last0 = e0.data;
            end
         end else begin
            checkVal("c0_rdata_hold", c0_rdata, last0);
            if (q0.size() > 0 && q0[0].due <= cycle) begin
               errors++;
               $display("[TB] FAIL c0_rvalid_missing: got rvalid=0, expected 1 (cycle %0d)", cycle);
               e0 = q0.pop_front();
            end
         end
         if (c1_rvalid) begin
            checks++;
            if (q1.size() == 0) begin
               errors++;
               $display("[TB] FAIL c1_rvalid_extra: got rvalid=1, expected 0 (cycle %0d)", cycle);
            end else begin
               e1 = q1.pop_front();
               if (c1_rdata !== e1.data || e1.due != cycle) begin
                  errors++;
                  $display("[TB] FAIL c1_rdata: got %h at cycle %0d, expected %h at cycle %0d",
                           c1_rdata, cycle, e1.data, e1.due);
               end
               last1 = e1.data;
            end
         end else begin
            checkVal("c1_rdata_hold", c1_rdata, last1);
            if (q1.size() > 0 && q1[0].due <= cycle) begin
               errors++;
               $display("[TB] FAIL c1_rvalid_missing: got rvalid=0, expected 1 (cycle %0d)", cycle);
               e1 = q1.pop_front();
            end
         end
      end
   end

   initial begin
      logic       p0, p1, w0, w1;
      logic [1:0] a0, a1;
      logic [3:0] d0, d1;
      for (int i = 0; i < 4; i++) m_mem[i] = 4'h0;
      resetModel();
      rst_n = 1'b0;
      c0_req = 1'b1; c0_we = 1'b0; c0_addr = 2'd0; c0_wdata = 4'h0;
      c1_req = 1'b1; c1_we = 1'b0; c1_addr = 2'd1; c1_wdata = 4'h0;

      $display("[TB] reset with requests held");
      repeat (2) @(posedge clk);
      #2;
      checkVal("rst_c0_gnt", c0_gnt, 0);
      checkVal("rst_c1_gnt", c1_gnt, 0);
      checkVal("rst_ram_ena", ram_ena, 0);
      checkVal("rst_ram_enb", ram_enb, 0);
      checkVal("rst_ram_wra", ram_wra, 0);
      checkVal("rst_ram_wrb", ram_wrb, 0);
      checkVal("rst_c0_rvalid", c0_rvalid, 0);
      checkVal("rst_c1_rvalid", c1_rvalid, 0);
      checkVal("rst_c0_rdata", c0_rdata, 0);
      checkVal("rst_c1_rdata", c1_rdata, 0);
      checkVal("rst_pri", dut.pri, 0);
      checkVal("rst_cnt", dut.conflict_cnt, 0);
      rst_n = 1'b1;
      #1;
      checkVal("release_c0_gnt", c0_gnt, 1);
      checkVal("release_c1_gnt", c1_gnt, 1);
      @(negedge clk);
      checkOutput();

      $display("[TB] parallel writes then crossed reads");
      applyStimulus(1, 1, 2'd0, 4'h5, 1, 1, 2'd1, 4'hA);
      applyStimulus(1, 0, 2'd1, 4'h0, 1, 0, 2'd0, 4'h0);
      checkVal("t2_exp_c0", q0[0].data, 4'hA);
      checkVal("t2_exp_c1", q1[0].data, 4'h5);

      $display("[TB] write-write conflict");
      applyStimulus(1, 1, 2'd2, 4'h3, 1, 1, 2'd2, 4'hC);
      applyStimulus(0, 0, 2'd0, 4'h0, 1, 1, 2'd2, 4'hC);
      applyStimulus(1, 0, 2'd2, 4'h0, 0, 0, 2'd0, 4'h0);
      checkVal("t3_read_addr2", q0[0].data, 4'hC);

      $display("[TB] read-write conflict");
      applyStimulus(1, 1, 2'd3, 4'h7, 0, 0, 2'd0, 4'h0);
      applyStimulus(1, 0, 2'd3, 4'h0, 1, 1, 2'd3, 4'h9);
      checkVal("t4_c0_loses", mg0, 0);
      applyStimulus(1, 0, 2'd3, 4'h0, 0, 0, 2'd0, 4'h0);
      checkVal("t4_read_new", q0[0].data, 4'h9);

      $display("[TB] read-read same address");
      applyStimulus(1, 0, 2'd0, 4'h0, 1, 0, 2'd0, 4'h0);
      applyStimulus(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0);

      $display("[TB] randomized traffic");
      p0 = 0; p1 = 0;
      w0 = 0; w1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
      for (int i = 0; i < 400; i++) begin
         if (!p0 && $urandom_range(0, 9) < 7) begin
            p0 = 1; w0 = 1'($urandom_range(0, 1));
            a0 = 2'($urandom_range(0, 3)); d0 = 4'($urandom_range(0, 15));
         end
         if (!p1 && $urandom_range(0, 9) < 7) begin
            p1 = 1; w1 = 1'($urandom_range(0, 1));
            a1 = 2'($urandom_range(0, 3)); d1 = 4'($urandom_range(0, 15));
         end
         applyStimulus(p0, w0, a0, d0, p1, w1, a1, d1);
         if (mg0) p0 = 0;
         if (mg1) p1 = 0;
      end

      $display("[TB] sustained conflicts");
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1, 1, 2'd1, 4'h6, 1, 1, 2'd1, 4'hB);
      end
      applyStimulus(1, 0, 2'd1, 4'h0, 0, 0, 2'd0, 4'h0);
      checkVal("cnt_saturated", dut.conflict_cnt, 255);

      $display("[TB] asynchronous reset during read");
      @(posedge clk);
      #1;
      c0_req = 0; c1_req = 0;
      checkVal("pre_rst_rvalid", c0_rvalid, 1);
      #1;
      rst_n = 1'b0;
      #1;
      checkVal("mid_rst_rvalid", c0_rvalid, 0);
      checkVal("mid_rst_rdata", c0_rdata, 0);
      checkVal("mid_rst_cnt", dut.conflict_cnt, 0);
      checkVal("mid_rst_pri", dut.pri, 0);
      resetModel();
      @(negedge clk);
      #2;
      rst_n = 1'b1;

      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
         if (c0_req && !mg0) applyStimulus(c0_req, c0_we, c0_addr, c0_wdata, 0, 0, 2'd0, 4'h0);
         if (c1_req && !mg1) applyStimulus(0, 0, 2'd0, 4'h0, c1_req, c1_we, c1_addr, c1_wdata);
      end
      applyStimulus(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0);
      applyStimulus(0, 0, 2'd0, 4'h0, 0, 0, 2'd0, 4'h0);
      checkVal("q0_drained", q0.size(), 0);
      checkVal("q1_drained", q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
